// File: rtl/hazard_scoreboard_if.sv
// Decode-to-scoreboard hazard request bundle.
// Decode drives its source/destination fields; the scoreboard answers with hazard.
interface hazard_scoreboard_if;
    logic [3:0] id_rn;
    logic [3:0] id_rdm;
    logic       id_two_src;
    logic [3:0] id_dest;
    logic       id_wb_en;
    logic       id_mem_read;
    logic       hazard;

    modport master (
        output id_rn, id_rdm, id_two_src,
        output id_dest, id_wb_en, id_mem_read,
        input  hazard
    );

    modport slave (
        input  id_rn, id_rdm, id_two_src,
        input  id_dest, id_wb_en, id_mem_read,
        output hazard
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard detection / forwarding control with an EXE-MEM-WB destination scoreboard.
// Optional macro HAZARD_FORWARD_EN enables forwarding (load-use stalls only).
module hazard_scoreboard #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    hazard_scoreboard_if.slave req,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b,
    output logic [CNT_W-1:0] stall_count
);

`ifdef HAZARD_FORWARD_EN
    typedef struct packed {
        logic       valid;
        logic [3:0] dest;
        logic       wb_en;
        logic       mem_read;
        logic [3:0] rn;
        logic [3:0] rdm;
        logic       two_src;
    } slot_t;
`else
    typedef struct packed {
        logic       valid;
        logic [3:0] dest;
        logic       wb_en;
        logic       mem_read;
    } slot_t;
`endif

    slot_t exe_q;
    slot_t mem_q;
    slot_t exe_d;
    logic  haz;

    // R15 reads the PC in decode, so it never matches a pending write
    function automatic logic hit(slot_t s, logic [3:0] src);
        return s.valid && s.wb_en && (s.dest == src) && (src != 4'hf);
    endfunction

`ifdef HAZARD_FORWARD_EN
    slot_t wb_q;
    logic  unused_slots;

    function automatic logic [1:0] sel(
        slot_t e, slot_t m, slot_t w, logic [3:0] src, logic live
    );
        if (!e.valid || !live)
            return 2'b00;
        if (hit(m, src) && !m.mem_read)
            return 2'b01;
        if (hit(w, src))
            return 2'b10;
        return 2'b00;
    endfunction

    // only a load still in EXE cannot be forwarded in time
    always_comb begin
        haz = (hit(exe_q, req.id_rn) ||
               (req.id_two_src && hit(exe_q, req.id_rdm))) &&
              exe_q.mem_read;
    end

    // EXE operand sources: MEM result first, then WB value
    always_comb begin
        fwd_sel_a = sel(exe_q, mem_q, wb_q, exe_q.rn, 1'b1);
        fwd_sel_b = sel(exe_q, mem_q, wb_q, exe_q.rdm, exe_q.two_src);
    end

    assign unused_slots = ^{wb_q, mem_q};

    // WB slot is only needed as a forwarding source
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wb_q <= '0;
        else if (!freeze)
            wb_q <= mem_q;
    end
`else
    logic unused_slots;

    // no bypass: any pending EXE or MEM write blocks decode
    always_comb begin
        haz = hit(exe_q, req.id_rn) || hit(mem_q, req.id_rn) ||
              (req.id_two_src &&
               (hit(exe_q, req.id_rdm) || hit(mem_q, req.id_rdm)));
    end

    assign fwd_sel_a = 2'b00;
    assign fwd_sel_b = 2'b00;
    assign unused_slots = mem_q.mem_read;
`endif

    assign req.hazard = haz;

    // next EXE entry: the decoded instruction, or a bubble on stall/flush
    always_comb begin
        exe_d = '0;
        if (!(haz || flush)) begin
            exe_d.valid    = 1'b1;
            exe_d.dest     = req.id_dest;
            exe_d.wb_en    = req.id_wb_en;
            exe_d.mem_read = req.id_mem_read;
`ifdef HAZARD_FORWARD_EN
            exe_d.rn       = req.id_rn;
            exe_d.rdm      = req.id_rdm;
            exe_d.two_src  = req.id_two_src;
`endif
        end
    end

    // scoreboard shifts in lock-step with the pipeline registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_q <= '0;
            mem_q <= '0;
        end else if (!freeze) begin
            exe_q <= exe_d;
            mem_q <= exe_q;
        end
    end

    // saturating count of stalled cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_count <= '0;
        else if (!freeze && haz && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: reference model feeding an expected-value queue.
// Covers both builds of HAZARD_FORWARD_EN and a CNT_W=2 saturation instance.
module tb_hazard_scoreboard;

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic freeze;
    logic flush;
    logic [3:0] rn, rdm, dest;
    logic two, wb, ld;
    logic [1:0] fa, fb, fa2, fb2;
    logic [15:0] cnt;
    logic [1:0] cnt2;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if bus ();
    hazard_scoreboard_if bus2 ();

    assign bus.id_rn = rn;
    assign bus.id_rdm = rdm;
    assign bus.id_two_src = two;
    assign bus.id_dest = dest;
    assign bus.id_wb_en = wb;
    assign bus.id_mem_read = ld;
    assign bus2.id_rn = rn;
    assign bus2.id_rdm = rdm;
    assign bus2.id_two_src = two;
    assign bus2.id_dest = dest;
    assign bus2.id_wb_en = wb;
    assign bus2.id_mem_read = ld;

    hazard_scoreboard #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .req(bus.slave), .fwd_sel_a(fa), .fwd_sel_b(fb),
        .stall_count(cnt)
    );

    hazard_scoreboard #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .req(bus2.slave), .fwd_sel_a(fa2), .fwd_sel_b(fb2),
        .stall_count(cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic v;
        logic [3:0] d;
        logic w;
        logic l;
        logic [3:0] a;
        logic [3:0] b;
        logic t;
    } ms_t;

    typedef struct {
        logic haz;
        logic [1:0] fa;
        logic [1:0] fb;
        int cnt;
        int cnt2;
    } exp_t;

    ms_t mx, mm, mw;
    int m_cnt, m_cnt2;
    exp_t q[$];

    function automatic logic mhit(ms_t s, logic [3:0] r);
        return s.v && s.w && (s.d == r) && (r != 4'd15);
    endfunction

    function automatic logic mhaz(logic [3:0] a, logic [3:0] b, logic t);
        if (FWD)
            return (mhit(mx, a) || (t && mhit(mx, b))) && mx.l;
        return mhit(mx, a) || mhit(mm, a) ||
               (t && (mhit(mx, b) || mhit(mm, b)));
    endfunction

    function automatic logic [1:0] msel(logic [3:0] r, logic live);
        if (!FWD || !mx.v || !live)
            return 2'd0;
        if (mhit(mm, r) && !mm.l)
            return 2'd1;
        if (mhit(mw, r))
            return 2'd2;
        return 2'd0;
    endfunction

    task automatic m_reset();
        mx = '0;
        mm = '0;
        mw = '0;
        m_cnt = 0;
        m_cnt2 = 0;
    endtask

    // one decode cycle: drive at negedge, check, model the edge
    task automatic step(input logic [3:0] a, input logic [3:0] b,
                        input logic t, input logic [3:0] d,
                        input logic w, input logic l,
                        input logic fl, input logic fz,
                        output logic h);
        exp_t e;
        exp_t o;
        ms_t nx;
        rn = a; rdm = b; two = t; dest = d;
        wb = w; ld = l; flush = fl; freeze = fz;
        e.haz = mhaz(a, b, t);
        e.fa = msel(mx.a, 1'b1);
        e.fb = msel(mx.b, mx.t);
        e.cnt = m_cnt;
        e.cnt2 = m_cnt2;
        q.push_back(e);
        #1;
        o = q.pop_front();
        check("hazard", 32'(bus.hazard), 32'(o.haz));
        check("hazard_w2", 32'(bus2.hazard), 32'(o.haz));
        check("fwd_sel_a", 32'(fa), 32'(o.fa));
        check("fwd_sel_b", 32'(fb), 32'(o.fb));
        check("stall_count", 32'(cnt), o.cnt);
        check("stall_count_w2", 32'(cnt2), o.cnt2);
        h = o.haz;
        @(posedge clk);
        if (!fz) begin
            nx = '0;
            if (!(o.haz || fl))
                nx = '{1'b1, d, w, l, a, b, t};
            mw = mm;
            mm = mx;
            mx = nx;
            if (o.haz) begin
                m_cnt++;
                if (m_cnt2 < 3)
                    m_cnt2++;
            end
        end
        @(negedge clk);
    endtask

    task automatic nops(input int n);
        logic h;
        for (int i = 0; i < n; i++)
            step(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, h);
    endtask

    // present one instruction until decode accepts it (bounded)
    task automatic issue(input logic [3:0] a, input logic [3:0] b,
                         input logic t, input logic [3:0] d,
                         input logic w, input logic l);
        logic h;
        for (int i = 0; i < 6; i++) begin
            step(a, b, t, d, w, l, 1'b0, 1'b0, h);
            if (!h)
                break;
        end
    endtask

    initial begin
        logic h;
        int base;
        m_reset();
        rst = 1'b0; freeze = 1'b0; flush = 1'b0;
        rn = 4'd3; rdm = 4'd3; two = 1'b1;
        dest = 4'd3; wb = 1'b1; ld = 1'b1;
        @(negedge clk);
        #1;
        check("rst_hazard", 32'(bus.hazard), 0);
        check("rst_count", 32'(cnt), 0);
        check("rst_sel_a", 32'(fa), 0);
        check("rst_sel_b", 32'(fb), 0);
        @(negedge clk);
        rst = 1'b1;
        nops(2);

        // ALU producer then dependent ALU consumer on Rn
        base = m_cnt;
        issue(4'd4, 4'd5, 1'b1, 4'd1, 1'b1, 1'b0);
        issue(4'd1, 4'd5, 1'b0, 4'd6, 1'b1, 1'b0);
        check("add_sub_sel_a", 32'(fa), FWD ? 1 : 0);
        nops(3);
        check("add_sub_stalls", 32'(cnt), base + (FWD ? 0 : 2));

        // load then consumer on Rm
        base = m_cnt;
        issue(4'd7, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1);
        issue(4'd4, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0);
        check("ldr_add_sel_b", 32'(fb), FWD ? 2 : 0);
        nops(3);
        check("ldr_add_stalls", 32'(cnt), base + (FWD ? 1 : 2));

        // same pair with the second source dead
        base = m_cnt;
        issue(4'd7, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1);
        issue(4'd4, 4'd2, 1'b0, 4'd3, 1'b1, 1'b0);
        nops(3);
        check("one_src_stalls", 32'(cnt), base);

        // freeze held during a load-use hazard
        base = m_cnt;
        issue(4'd0, 4'd0, 1'b0, 4'd8, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(4'd8, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1, h);
            check("freeze_hazard", 32'(bus.hazard), 1);
            check("freeze_count", 32'(cnt), base);
        end
        issue(4'd8, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0);
        nops(3);
        check("freeze_stalls", 32'(cnt), base + (FWD ? 1 : 2));

        // flush together with hazard, then an unrelated decode
        issue(4'd0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b1);
        step(4'd9, 4'd0, 1'b0, 4'd10, 1'b1, 1'b0, 1'b1, 1'b0, h);
        step(4'd0, 4'd10, 1'b1, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0, h);
        nops(3);

        // R15 is never a hazard source
        issue(4'd0, 4'd0, 1'b0, 4'd15, 1'b1, 1'b1);
        step(4'd15, 4'd15, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, h);
        check("r15_no_stall", 32'(bus.hazard), 0);
        nops(3);

        // asynchronous reset in the middle of a stall
        issue(4'd0, 4'd0, 1'b0, 4'd11, 1'b1, 1'b1);
        rn = 4'd11; two = 1'b0; ld = 1'b0; freeze = 1'b0; flush = 1'b0;
        #1;
        check("pre_rst_hazard", 32'(bus.hazard), 1);
        rst = 1'b0;
        #1;
        check("mid_rst_hazard", 32'(bus.hazard), 0);
        check("mid_rst_count", 32'(cnt), 0);
        check("mid_rst_count_w2", 32'(cnt2), 0);
        m_reset();
        @(negedge clk);
        rst = 1'b1;

        // five load-use pairs: narrow counter must pin at 3
        for (int i = 0; i < 5; i++) begin
            issue(4'd0, 4'd0, 1'b0, 4'd10, 1'b1, 1'b1);
            issue(4'd10, 4'd0, 1'b0, 4'd12, 1'b1, 1'b0);
        end
        nops(3);
        check("sat_count_w2", 32'(cnt2), 3);
        check("sat_count", 32'(cnt), FWD ? 5 : 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Hazard-detection and forwarding-control unit for the five-stage ARM pipeline; it is the responder to the decode stage's hazard request interface. Each cycle it compares the decode stage's source registers (Rn, Rd/Rm, two-source flag) against a three-slot scoreboard of in-flight destinations (EXE, MEM, WB) and returns the `hazard` stall. The scoreboard is shifted in lock-step with the pipeline registers. It also drives EXE-stage forwarding selects and a saturating stall counter.

## Interface
- `CNT_W`, 16, width of the stall counter.
- `clk` in 1: pipeline clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `freeze` in 1: global pipeline freeze (memory wait); scoreboard holds.
- `flush` in 1: branch taken in EXE; decode instruction is squashed.
- `id_rn` in 4: decode Rn (`instruction[19:16]`).
- `id_rdm` in 4: decode second source (Rm, or Rd for stores).
- `id_two_src` in 1: second source is live (`~imm | mem_write`).
- `id_dest` in 4: decode destination (`instruction[15:12]`).
- `id_wb_en` in 1: decode instruction writes back.
- `id_mem_read` in 1: decode instruction is a load.
- `hazard` out 1: stall decode and fetch; decode injects a bubble.
- `fwd_sel_a` out 2: EXE operand-1 source: 00 register file, 01 MEM result, 10 WB value.
- `fwd_sel_b` out 2: EXE operand-2 source, same encoding.
- `stall_count` out CNT_W: number of cycles in which `hazard` was asserted.

## Operation
- Slot fields: `valid`, `dest`[3:0], `wb_en`, `mem_read`, `rn`[3:0], `rdm`[3:0], `two_src`.
- Match on a slot: `valid & wb_en & (dest == src)`.
- R15 is never a hazard source: `id_rn == 15` and `id_rdm == 15` match nothing, because decode substitutes the PC.
- `id_rdm` is only compared when `id_two_src` = 1.
- WB slot never causes a hazard. The register file writes before it reads in the same cycle.
- Hazard rule without forwarding: a source matches the EXE slot or the MEM slot.
- Hazard rule with forwarding: a source matches the EXE slot and `EXE.mem_read` = 1 (load-use only).
- `hazard` is combinational from the slots and the `id_*` inputs.
- Slot update on a rising edge when `freeze` = 0:
  - WB <= MEM; MEM <= EXE.
  - EXE <= bubble (`valid` = 0) if `hazard` or `flush`; otherwise EXE <= `{1, id_*}`.
- `flush` and `hazard` together: EXE <= bubble, same as either alone.
- `freeze` = 1: every slot holds. `hazard` is still evaluated. `stall_count` holds.
- Forwarding selects are combinational from the EXE slot's `rn`/`rdm`:
  - 01 if the source matches the MEM slot and `MEM.mem_read` = 0.
  - Else 10 if the source matches the WB slot.
  - Else 00.
  - MEM has priority over WB. R15 always gives 00. An invalid EXE slot gives 00.
- `stall_count` increments by 1 on each unfrozen edge where `hazard` = 1. It saturates at 2^CNT_W−1 and never wraps.

## Timing
- Reset (`rst` low, asynchronous): all slot `valid` = 0, `stall_count` = 0.
- While in reset, and in the first cycle after it, `hazard` = 0 and `fwd_sel_a` = `fwd_sel_b` = 00 for any `id_*` input.
- `hazard` has zero-cycle latency from the `id_*` inputs; it settles within the same cycle as decode.
- A load followed by a dependent instruction stalls exactly 1 cycle with forwarding, and 2 cycles without it.
- A dependent ALU pair stalls 0 cycles with forwarding, and 2 cycles without it.
- A `rst` assertion mid-stall clears the scoreboard immediately; `hazard` drops in the same cycle.

## Configuration
- Macro: `HAZARD_FORWARD_EN`.
- Defined:
  - Forwarding rule applies (load-use hazard only).
  - `fwd_sel_a`/`fwd_sel_b` are driven as specified.
- Undefined:
  - Full EXE/MEM hazard rule applies.
  - `fwd_sel_a` = `fwd_sel_b` = 00 constantly.
  - The `rn`/`rdm`/`two_src` slot fields are not stored.

## Test plan
- Reset: `rst` low with `id_rn` = 3 and all slots invalid -> `hazard` = 0, `stall_count` = 0, selects 00.
- ADD R1 then SUB using R1 as Rn:
  - No macro -> `hazard` high 2 cycles; `stall_count` = 2.
  - With macro -> no stall; `fwd_sel_a` = 01 when SUB is in EXE.
- LDR R2 then ADD using R2 as Rm (`id_two_src` = 1):
  - With macro -> 1-cycle stall, then `fwd_sel_b` = 10.
  - `id_two_src` = 0 -> no stall.
- `freeze` held 3 cycles during a hazard -> slots and `stall_count` unchanged; `hazard` stays 1; stalling resumes after release.
- `flush` in the same cycle as `hazard` -> EXE slot becomes a bubble; the next cycle shows no match from that slot. `id_rn` = 15 never stalls.
- `CNT_W` = 2 with 5 consecutive stall cycles -> `stall_count` saturates at 3.
